// File: rtl/up_down_counter_mod_if.sv
`default_nettype none
// ============================================================================
//  Module      : up_down_counter_mod_if
//  Description : Control/status bundle for the up_down_counter_mod counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface up_down_counter_mod_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_down;
    logic             sync_clr;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             overflow;
    logic             underflow;

    modport master (
        output en, up_down, sync_clr, load, load_value,
        input  count, at_max, at_zero, overflow, underflow
    );

    modport slave (
        input  en, up_down, sync_clr, load, load_value,
        output count, at_max, at_zero, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/up_down_counter_mod.sv
`default_nettype none
// ============================================================================
//  Module      : up_down_counter_mod
//  Description : Modulo/saturating up/down counter with clear, load and
//                registered overflow/underflow pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module up_down_counter_mod #(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_VALUE = (32'd1 << WIDTH) - 32'd1,
    parameter bit          SATURATE  = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    up_down_counter_mod_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("up_down_counter_mod: WIDTH out of range 1..32");
        end
        if (MAX_VALUE < 1 || (WIDTH < 32 && MAX_VALUE > ((32'd1 << WIDTH) - 32'd1))) begin : g_bad_max
            $error("up_down_counter_mod: MAX_VALUE out of range");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_load_clamped = (bus.load_value > c_max) ? c_max : bus.load_value;
    assign w_at_max       = (r_count == c_max);
    assign w_at_zero      = (r_count == c_zero);

    // Bound checks compare against c_max/zero before stepping, so the
    // binary rollover of WIDTH bits is never relied upon.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= c_zero;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (bus.sync_clr) begin
                r_count <= c_zero;
            end else if (bus.load) begin
                r_count <= w_load_clamped;
            end else if (bus.en) begin
                if (bus.up_down) begin
                    if (w_at_max) begin
                        r_overflow <= 1'b1;
                        if (!SATURATE) begin
                            r_count <= c_zero;
                        end
                    end else begin
                        r_count <= r_count + c_one;
                    end
                end else begin
                    if (w_at_zero) begin
                        r_underflow <= 1'b1;
                        if (!SATURATE) begin
                            r_count <= c_max;
                        end
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
            end
        end
    end

    assign bus.count     = r_count;
    assign bus.at_max    = w_at_max;
    assign bus.at_zero   = w_at_zero;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter_mod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_up_down_counter_mod
//  Description : Scoreboard bench for three counter configurations sharing
//                one stimulus stream against a behavioural counter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_up_down_counter_mod;

    typedef struct packed {
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up_down, sync_clr, load;
    logic [3:0] load_value;

    int vectors     = 0;
    int miscompares = 0;

    // cfg0: W4 M9 wrap, cfg1: W4 M9 saturate, cfg2: W3 M7 wrap
    int mx   [3] = '{9, 9, 7};
    int sat  [3] = '{0, 1, 0};
    int mask [3] = '{15, 15, 7};
    int mc   [3] = '{0, 0, 0};
    int mo   [3] = '{0, 0, 0};
    int mu   [3] = '{0, 0, 0};

    exp_t q [3][$];

    always #5 clk = ~clk;

    up_down_counter_mod_if #(.WIDTH(4)) if0 ();
    up_down_counter_mod_if #(.WIDTH(4)) if1 ();
    up_down_counter_mod_if #(.WIDTH(3)) if2 ();

    assign if0.en = en;  assign if0.up_down = up_down;  assign if0.sync_clr = sync_clr;
    assign if0.load = load;  assign if0.load_value = load_value;
    assign if1.en = en;  assign if1.up_down = up_down;  assign if1.sync_clr = sync_clr;
    assign if1.load = load;  assign if1.load_value = load_value;
    assign if2.en = en;  assign if2.up_down = up_down;  assign if2.sync_clr = sync_clr;
    assign if2.load = load;  assign if2.load_value = load_value[2:0];

    up_down_counter_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    up_down_counter_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    up_down_counter_mod #(.WIDTH(3), .MAX_VALUE(7), .SATURATE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .bus(if2.slave));

    logic [3:0] dcnt [3];
    logic       dov  [3];
    logic       dun  [3];
    logic       dmax [3];
    logic       dzer [3];

    assign dcnt[0] = if0.count;          assign dov[0] = if0.overflow;  assign dun[0] = if0.underflow;
    assign dcnt[1] = if1.count;          assign dov[1] = if1.overflow;  assign dun[1] = if1.underflow;
    assign dcnt[2] = {1'b0, if2.count};  assign dov[2] = if2.overflow;  assign dun[2] = if2.underflow;
    assign dmax[0] = if0.at_max;  assign dzer[0] = if0.at_zero;
    assign dmax[1] = if1.at_max;  assign dzer[1] = if1.at_zero;
    assign dmax[2] = if2.at_max;  assign dzer[2] = if2.at_zero;

    // Behavioural counter: next value from the counting rules on integers.
    task automatic model_step(input int k, input bit r, input bit e, input bit u,
                              input bit c, input bit l, input int lv);
        int lvk;
        lvk   = lv & mask[k];
        mo[k] = 0;
        mu[k] = 0;
        if (!r || c) begin
            mc[k] = 0;
        end else if (l) begin
            mc[k] = (lvk > mx[k]) ? mx[k] : lvk;
        end else if (e && u) begin
            if (mc[k] == mx[k]) begin
                mo[k] = 1;
                mc[k] = sat[k] ? mx[k] : 0;
            end else begin
                mc[k] = mc[k] + 1;
            end
        end else if (e) begin
            if (mc[k] == 0) begin
                mu[k] = 1;
                mc[k] = sat[k] ? 0 : mx[k];
            end else begin
                mc[k] = mc[k] - 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit u, input bit c,
                       input bit l, input int lv);
        exp_t ex;
        @(negedge clk);
        #1;
        reset = r; en = e; up_down = u; sync_clr = c; load = l;
        load_value = 4'(lv);
        for (int k = 0; k < 3; k++) begin
            model_step(k, r, e, u, c, l, lv);
            ex.cnt = 4'(mc[k]);
            ex.ovf = mo[k][0];
            ex.unf = mu[k][0];
            q[k].push_back(ex);
        end
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (dcnt[k] !== 4'd0 || dov[k] !== 1'b0 || dun[k] !== 1'b0 ||
                dzer[k] !== 1'b1 || dmax[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: got cnt=%0d ovf=%b unf=%b max=%b zero=%b, want cnt=0 ovf=0 unf=0 max=0 zero=1",
                         k, dcnt[k], dov[k], dun[k], dmax[k], dzer[k]);
            end
            mc[k] = 0; mo[k] = 0; mu[k] = 0;
        end
    endtask

    // Monitor: every settled cycle is an output; compare against the oldest expectation.
    initial begin
        exp_t ex;
        logic emax, ezer;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (q[k].size() > 0) begin
                    ex   = q[k].pop_front();
                    emax = (int'(ex.cnt) == mx[k]);
                    ezer = (ex.cnt == 4'd0);
                    vectors++;
                    if (dcnt[k] !== ex.cnt || dov[k] !== ex.ovf || dun[k] !== ex.unf ||
                        dmax[k] !== emax || dzer[k] !== ezer) begin
                        miscompares++;
                        $display("FAIL cycle_check dut%0d t=%0t: got cnt=%0d ovf=%b unf=%b max=%b zero=%b, want cnt=%0d ovf=%b unf=%b max=%b zero=%b",
                                 k, $time, dcnt[k], dov[k], dun[k], dmax[k], dzer[k],
                                 ex.cnt, ex.ovf, ex.unf, emax, ezer);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0; en = 1'b0; up_down = 1'b0; sync_clr = 1'b0; load = 1'b0;
        load_value = 4'd0;

        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        // Release and count up through the modulus
        for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0, 0, 0);
        // Down through the wrap from 1
        cyc(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
        // Upper and lower bound behaviour
        cyc(1, 0, 0, 0, 1, 8);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) cyc(1, 1, 0, 0, 0, 0);
        // Priority and load clamp
        cyc(1, 1, 1, 1, 1, 5);
        cyc(1, 1, 1, 0, 1, 15);
        cyc(1, 1, 0, 0, 1, 15);
        cyc(1, 0, 0, 0, 0, 0);
        // Asynchronous reset mid-count
        cyc(1, 0, 0, 0, 1, 5);
        cyc(1, 1, 1, 0, 0, 0);
        async_reset_check();
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        // Full-range run from zero
        cyc(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1, 1, 1, 0, 0, 0);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                int'($urandom_range(0, 15)));
        end
        cyc(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (q[k].size() != 0) begin
                miscompares++;
                $display("FAIL drain dut%0d: got %0d pending expectations, want 0", k, q[k].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
